// File: rtl/stim_gen.sv
// ============================================================================
//  Module   : stim_gen
//  Purpose  : Valid/ready frame generator: fixed-length frames, programmable
//             idle gaps, deterministic payload. Optional macro STIM_GEN_LFSR_EN
//             selects a 32-bit LFSR payload instead of an incrementing count.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module stim_gen #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [7:0]        cfg_gap,
    input  logic [15:0]       cfg_frames,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len_m1;
    logic [LEN_W-1:0]   r_beat;
    logic [7:0]         r_gap;
    logic [7:0]         r_gap_cnt;
    logic [15:0]        r_frames;
    logic               r_stop_pend;
    logic [DATA_W-1:0]  r_payload;

    logic [DATA_W-1:0]  w_payload_next;
    logic [LEN_W-1:0]   w_cfg_len_m1;
    logic [LEN_W-1:0]   w_beat_inc;
    logic [15:0]        w_frame_inc;
    logic               w_xfer;
    logic               w_run_end;

`ifdef STIM_GEN_LFSR_EN
    localparam logic [DATA_W-1:0] c_seed = {DATA_W{1'b1}};

    generate
        if (DATA_W != 32) begin : g_width_check
            $error("stim_gen: DATA_W must be 32 when STIM_GEN_LFSR_EN is defined");
        end
    endgenerate

    assign w_payload_next = {r_payload[DATA_W-2:0],
                             r_payload[31] ^ r_payload[21] ^ r_payload[1] ^ r_payload[0]};
`else
    localparam logic [DATA_W-1:0] c_seed = '0;

    assign w_payload_next = r_payload + DATA_W'(1);
`endif

    // A zero length is promoted to a single-beat frame.
    assign w_cfg_len_m1 = (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);
    assign w_beat_inc   = r_beat + LEN_W'(1);
    assign w_frame_inc  = frame_cnt + 16'd1;
    assign w_xfer       = m_valid & m_ready;
    assign w_run_end    = ((r_frames != 16'd0) && (w_frame_inc == r_frames))
                          || r_stop_pend || stop;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state     <= S_IDLE;
            r_len_m1    <= '0;
            r_beat      <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_frames    <= '0;
            r_stop_pend <= 1'b0;
            r_payload   <= c_seed;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len_m1    <= w_cfg_len_m1;
                        r_gap       <= cfg_gap;
                        r_frames    <= cfg_frames;
                        frame_cnt   <= '0;
                        r_beat      <= '0;
                        r_stop_pend <= 1'b0;
                        r_payload   <= c_seed;
                        m_data      <= c_seed;
                        m_valid     <= 1'b1;
                        m_last      <= (w_cfg_len_m1 == '0);
                        busy        <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_payload <= w_payload_next;
                        m_data    <= w_payload_next;
                        if (m_last) begin
                            frame_cnt <= w_frame_inc;
                            r_beat    <= '0;
                            if (w_run_end) begin
                                m_valid <= 1'b0;
                                m_last  <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= S_IDLE;
                            end else if (r_gap == 8'd0) begin
                                m_last <= (r_len_m1 == '0);
                            end else begin
                                m_valid   <= 1'b0;
                                m_last    <= 1'b0;
                                r_gap_cnt <= r_gap - 8'd1;
                                r_state   <= S_GAP;
                            end
                        end else begin
                            r_beat <= w_beat_inc;
                            m_last <= (w_beat_inc == r_len_m1);
                        end
                    end
                end

                S_GAP: begin
                    if (stop) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_gap_cnt == 8'd0) begin
                        m_valid <= 1'b1;
                        m_last  <= (r_len_m1 == '0);
                        r_state <= S_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stim_gen.sv
// ============================================================================
//  Module   : tb_stim_gen
//  Purpose  : Scoreboard bench for stim_gen: expected beats queued at start,
//             popped by an independent monitor on every handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stim_gen;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [7:0]        cfg_gap = '0;
    logic [15:0]       cfg_frames = '0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready = 1'b1;
    logic              busy;
    logic              done;
    logic [15:0]       frame_cnt;

    stim_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .start      (start),
        .stop       (stop),
        .cfg_len    (cfg_len),
        .cfg_gap    (cfg_gap),
        .cfg_frames (cfg_frames),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        fin;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          beats_seen = 0;
    int          runs_done = 0;
    int          exp_fc = 0;
    int          cur_gap = 0;
    int          idle_cnt = 0;
    int          ready_mode = 0;
    int          pat_idx = 0;
    bit          gap_req = 1'b0;
    bit          arm = 1'b0;
    bit          after_last = 1'b0;
    bit          stall = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Payload model: beat n of a run carries n, or the n-th LFSR state.
    function automatic logic [31:0] model_data(int idx);
`ifdef STIM_GEN_LFSR_EN
        logic [31:0] v = 32'hFFFF_FFFF;
        for (int i = 0; i < idx; i++) begin
            v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
        end
        return v;
`else
        return 32'(idx);
`endif
    endfunction

    task automatic push_run(int len, int frames, bit fin_at_end);
        int eff = (len == 0) ? 1 : len;
        int n = 0;
        for (int f = 0; f < frames; f++) begin
            for (int b = 0; b < eff; b++) begin
                exp_q.push_back('{model_data(n), (b == eff - 1),
                                  fin_at_end && (f == frames - 1) && (b == eff - 1)});
                n++;
            end
        end
    endtask

    task automatic issue_start(int len, int gap, int frames);
        @(posedge clk); #1;
        cfg_len    = LEN_W'(len);
        cfg_gap    = 8'(gap);
        cfg_frames = 16'(frames);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_valid", 32'(m_valid), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        cfg_len    = LEN_W'($urandom);
        cfg_gap    = 8'($urandom);
        cfg_frames = 16'($urandom);
    endtask

    task automatic wait_end(int prev);
        int n = 0;
        while (runs_done == prev && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        if (runs_done == prev) begin
            checks++;
            failures++;
            $display("FAIL run_end_timeout: got no done, expected done within 4000 cycles");
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run(int len, int gap, int frames, int mode);
        int prev;
        ready_mode = mode;
        cur_gap    = gap;
        exp_fc     = frames;
        push_run(len, frames, 1'b1);
        prev = runs_done;
        issue_start(len, gap, frames);
        wait_end(prev);
    endtask

    task automatic run_stop(int len, int gap, int k, bit in_gap, int mode);
        int prev;
        int base;
        int rel;
        bit hit = 1'b0;
        ready_mode = mode;
        cur_gap    = gap;
        exp_fc     = k;
        push_run(len, k, !in_gap);
        prev = runs_done;
        base = beats_seen;
        issue_start(len, gap, 0);
        for (int n = 0; n < 4000 && !hit; n++) begin
            @(posedge clk); #1;
            rel = beats_seen - base;
            if ((!in_gap && rel >= (k - 1) * len + 1 && rel <= k * len - 1) ||
                (in_gap && rel == k * len && !m_valid && busy)) begin
                stop = 1'b1;
                if (in_gap) gap_req = 1'b1;
                @(posedge clk); #1;
                stop = 1'b0;
                hit  = 1'b1;
            end
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL stop_window_timeout: got no stop window, expected one in frame %0d", k);
        end
        wait_end(prev);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                m_ready = pat[pat_idx];
                pat_idx = (pat_idx + 1) % 4;
            end
        endcase
    end

    // Monitor: samples mid-cycle, before the edge that acts on what it sees.
    always @(negedge clk) begin
        beat_t it;
        if (!rst_) begin
            stall      = 1'b0;
            after_last = 1'b0;
            arm        = 1'b0;
            gap_req    = 1'b0;
        end else begin
            chk("done_pulse", 32'(done), 32'(arm));
            if (arm) begin
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("frame_cnt_at_done", 32'(frame_cnt), 32'(exp_fc));
                after_last = 1'b0;
                runs_done++;
            end
            arm     = gap_req;
            gap_req = 1'b0;

            if (after_last && m_valid) begin
                chk("gap_len", 32'(idle_cnt), 32'(cur_gap));
                after_last = 1'b0;
            end else if (after_last) begin
                idle_cnt++;
            end

            if (stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", m_data, hold_data);
                chk("hold_last", 32'(m_last), 32'(hold_last));
            end

            if (m_valid && m_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data %h, expected no beat", m_data);
                end else begin
                    it = exp_q.pop_front();
                    chk("beat_data", m_data, it.data);
                    chk("beat_last", 32'(m_last), 32'(it.last));
                    if (it.fin) begin
                        arm = 1'b1;
                    end else if (it.last) begin
                        after_last = 1'b1;
                        idle_cnt   = 0;
                    end
                end
            end

            stall     = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
        end
    end

    task automatic check_reset_values();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        int base;
        int n;
        repeat (25) @(posedge clk);
        #1;
        check_reset_values();
        rst_ = 1'b1;

        run(4, 0, 2, 0);
        run(3, 5, 3, 0);
        run(4, 0, 1, 2);
        run(0, 1, 2, 1);

        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk("stop_in_idle_busy", 32'(busy), 32'd0);

        run_stop(2, 1, 5, 1'b0, 0);
        run_stop(2, 1, 3, 1'b1, 0);
        run_stop(3, 2, 2, 1'b0, 1);
        run_stop(4, 3, 2, 1'b1, 1);

        // Reset mid-frame of a continuous run.
        ready_mode = 0;
        cur_gap    = 0;
        exp_fc     = 0;
        push_run(4, 3, 1'b0);
        base = beats_seen;
        issue_start(4, 0, 0);
        n = 0;
        while (beats_seen - base < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_reset_progress", 32'(beats_seen - base >= 5), 32'd1);
        rst_ = 1'b0;
        @(posedge clk); #1;
        check_reset_values();
        exp_q.delete();
        @(posedge clk); #1;
        rst_ = 1'b1;
        run(3, 1, 2, 1);

        for (int i = 0; i < 8; i++) begin
            run(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                int'($urandom_range(1, 3)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
